awg_playlist_sequencer: RTL and testbench

- Sits directly upstream of the AD9910 parallel AWG engine(s) and drives their iAddr/iTrig/iStartAddr inputs.
- A host-loaded playlist of waveform records is walked in order. Each step triggers one AWG segment on a selected channel, waits for that segment to finish, then inserts a programmable gap.
- The playlist is repeated a programmed number of times, or indefinitely until abort.

---
 rtl/awg_pkg.sv | 30 +++
 rtl/awg_playlist_ram.sv | 36 +++
 rtl/awg_playlist_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_awg_playlist_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/awg_pkg.sv
// Shared definitions for the AWG playlist sequencer: state encoding and playlist entry layout.
package awg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_GAP       = 3'd5
    } state_t;

    localparam int unsigned ENTRY_W   = 32;
    localparam int unsigned START_LSB = 0;
    localparam int unsigned START_W   = 16;
    localparam int unsigned CH_LSB    = 16;
    localparam int unsigned CH_W      = 4;
    localparam int unsigned GAP_LSB   = 20;
    localparam int unsigned GAP_W     = 11;
    localparam int unsigned LAST_BIT  = 31;

    function automatic logic [GAP_W-1:0] entryGap(input logic [ENTRY_W-1:0] entry);
        return entry[GAP_LSB +: GAP_W];
    endfunction

    function automatic logic entryLast(input logic [ENTRY_W-1:0] entry);
        return entry[LAST_BIT];
    endfunction

endpackage

// File: rtl/awg_playlist_ram.sv
// Playlist storage: single write port, registered read port that only updates when iRdEn is high,
// so the read register doubles as the current-entry register.
module awg_playlist_ram #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 32
) (
    input  logic          iClk,
    input  logic          iReset,
    input  logic          iWrEn,
    input  logic [AW-1:0] iWrAddr,
    input  logic [DW-1:0] iWrData,
    input  logic          iRdEn,
    input  logic [AW-1:0] iRdAddr,
    output logic [DW-1:0] oRdData
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge iClk) begin
        if (iWrEn) begin
            mem[iWrAddr] <= iWrData;
        end
    end

    // Read-before-write: a same-cycle write to the read address shows up on the next read.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            oRdData <= '0;
        end else if (iRdEn) begin
            oRdData <= mem[iRdAddr];
        end
    end

endmodule

// File: rtl/awg_playlist_sequencer.sv
// Walks a host-loaded playlist, triggering one AWG segment per entry with a programmable gap.
// Optional ack timeout with sticky oErr is enabled by defining AWG_SEQ_ACK_TIMEOUT_EN.
module awg_playlist_sequencer
    import awg_pkg::*;
#(
    parameter int unsigned PL_AW       = 6,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic               iClk,
    input  logic               iReset,
    input  logic               iWrEn,
    input  logic [PL_AW-1:0]   iWrAddr,
    input  logic [31:0]        iWrData,
    input  logic               iStart,
    input  logic               iAbort,
    input  logic [15:0]        iLoops,
    input  logic               iReady,
    output logic [3:0]         oAddr,
    output logic               oTrig,
    output logic [15:0]        oStartAddr,
    output logic               oBusy,
    output logic               oDone,
    output logic [PL_AW-1:0]   oEntryIdx,
    output logic               oErr
);

    state_t             state;
    logic [PL_AW-1:0]   index;
    logic [15:0]        loops;
    logic [15:0]        pass;
    logic [GAP_W-1:0]   gapCnt;
    logic               abortPend;
    logic [ENTRY_W-1:0] entry;
    logic               abortNow;
    logic               endOfPass;
    logic               lastPass;
    logic               advance;

    awg_playlist_ram #(.AW(PL_AW), .DW(ENTRY_W)) uRam (
        .iClk    (iClk),
        .iReset  (iReset),
        .iWrEn   (iWrEn),
        .iWrAddr (iWrAddr),
        .iWrData (iWrData),
        .iRdEn   (state == ST_FETCH),
        .iRdAddr (index),
        .oRdData (entry)
    );

    // Channel and start address come straight from the entry register, held until the next FETCH.
    assign oAddr      = entry[CH_LSB +: CH_W];
    assign oStartAddr = entry[START_LSB +: START_W];
    assign oEntryIdx  = index;

    assign abortNow  = abortPend | iAbort;
    assign endOfPass = entryLast(entry) || (index == '1);
    assign lastPass  = (loops != 16'd0) && (pass == loops);
    assign advance   = !abortNow &&
                       (((state == ST_WAIT_DONE) && iReady && (entryGap(entry) == '0)) ||
                        ((state == ST_GAP) && (gapCnt == GAP_W'(1))));

`ifdef AWG_SEQ_ACK_TIMEOUT_EN
    localparam int unsigned ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    logic [ACK_W-1:0] ackCnt;
`else
    localparam int unsigned unusedAckTimeout = ACK_TIMEOUT;
    assign oErr = 1'b0;
`endif

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state     <= ST_IDLE;
            index     <= '0;
            loops     <= '0;
            pass      <= '0;
            gapCnt    <= '0;
            abortPend <= 1'b0;
            oTrig     <= 1'b0;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
`ifdef AWG_SEQ_ACK_TIMEOUT_EN
            ackCnt    <= '0;
            oErr      <= 1'b0;
`endif
        end else begin
            oTrig <= 1'b0;
            oDone <= 1'b0;
            if ((state != ST_IDLE) && iAbort) begin
                abortPend <= 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    abortPend <= 1'b0;
                    if (iStart && !iAbort) begin
                        loops <= iLoops;
                        pass  <= 16'd1;
                        index <= '0;
                        state <= ST_FETCH;
                        oBusy <= 1'b1;
`ifdef AWG_SEQ_ACK_TIMEOUT_EN
                        oErr  <= 1'b0;
`endif
                    end
                end
                ST_FETCH: begin
                    if (abortNow) begin
                        state <= ST_IDLE;
                        oBusy <= 1'b0;
                        oDone <= 1'b1;
                    end else begin
                        state <= ST_ISSUE;
                        oTrig <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT_ACK;
`ifdef AWG_SEQ_ACK_TIMEOUT_EN
                    ackCnt <= '0;
`endif
                end
                ST_WAIT_ACK: begin
                    if (!iReady) begin
                        state <= ST_WAIT_DONE;
`ifdef AWG_SEQ_ACK_TIMEOUT_EN
                    end else if (ackCnt == ACK_W'(ACK_TIMEOUT - 1)) begin
                        oErr  <= 1'b1;
                        state <= ST_IDLE;
                        oBusy <= 1'b0;
                        oDone <= 1'b1;
                    end else begin
                        ackCnt <= ackCnt + ACK_W'(1);
`endif
                    end
                end
                ST_WAIT_DONE: begin
                    if (iReady) begin
                        if (abortNow) begin
                            state <= ST_IDLE;
                            oBusy <= 1'b0;
                            oDone <= 1'b1;
                        end else if (entryGap(entry) != '0) begin
                            gapCnt <= entryGap(entry);
                            state  <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (abortNow) begin
                        state <= ST_IDLE;
                        oBusy <= 1'b0;
                        oDone <= 1'b1;
                    end else if (gapCnt != GAP_W'(1)) begin
                        gapCnt <= gapCnt - GAP_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    oBusy <= 1'b0;
                end
            endcase

            // Step to the next entry, the next pass, or finish.
            if (advance) begin
                if (!endOfPass) begin
                    index <= index + PL_AW'(1);
                    state <= ST_FETCH;
                end else if (lastPass) begin
                    state <= ST_IDLE;
                    oBusy <= 1'b0;
                    oDone <= 1'b1;
                end else begin
                    pass  <= (pass == 16'hFFFF) ? pass : pass + 16'd1;
                    index <= '0;
                    state <= ST_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_awg_playlist_sequencer.sv
// Self-checking bench: an event-level schedule model predicts trigger cycles, done and busy windows.
module tb_awg_playlist_sequencer;

    localparam int unsigned PL_AW = 6;
    localparam int BUSY = 10;
    localparam int NEVER = 1 << 30;

    logic             iClk = 1'b0;
    logic             iReset;
    logic             iWrEn;
    logic [PL_AW-1:0] iWrAddr;
    logic [31:0]      iWrData;
    logic             iStart;
    logic             iAbort;
    logic [15:0]      iLoops;
    logic             iReady;
    logic [3:0]       oAddr;
    logic             oTrig;
    logic [15:0]      oStartAddr;
    logic             oBusy;
    logic             oDone;
    logic [PL_AW-1:0] oEntryIdx;
    logic             oErr;

    awg_playlist_sequencer #(.PL_AW(PL_AW), .ACK_TIMEOUT(8)) dut (
        .iClk       (iClk),
        .iReset     (iReset),
        .iWrEn      (iWrEn),
        .iWrAddr    (iWrAddr),
        .iWrData    (iWrData),
        .iStart     (iStart),
        .iAbort     (iAbort),
        .iLoops     (iLoops),
        .iReady     (iReady),
        .oAddr      (oAddr),
        .oTrig      (oTrig),
        .oStartAddr (oStartAddr),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oEntryIdx  (oEntryIdx),
        .oErr       (oErr)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    // Emulated AWG: goes busy the cycle after a trigger and stays busy for BUSY cycles.
    int   awgCnt = 0;
    logic awgMute = 1'b0;
    always @(posedge iClk) begin
        if (oTrig && !awgMute) awgCnt <= BUSY;
        else if (awgCnt != 0)  awgCnt <= awgCnt - 1;
    end
    assign iReady = (awgCnt == 0);

    typedef struct {
        int          t;
        int          idx;
        logic [3:0]  ch;
        logic [15:0] sa;
    } trig_t;

    logic [31:0] pl [64];
    trig_t expQ[$];
    int    trigSeen[$];
    int    busyFrom = NEVER, busyTo = NEVER, expDone = -1;
    int    errFrom = 0, errTo = 0;
    int    doneSeen = -1, doneCount = 0;
    bit    modelOn = 0;
    int    nChk = 0, nFail = 0;
    bit    expTrig;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic runTo(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wr(input int idx, input logic [31:0] data);
        iWrEn = 1'b1; iWrAddr = PL_AW'(idx); iWrData = data;
        tick();
        iWrEn = 1'b0;
        pl[idx] = data;
    endtask

    // Trigger k+1 follows trigger k by BUSY+3+gap cycles; the final pass ends BUSY+2+gap after its last trigger.
    task automatic plan(input int s, input int loops, input int maxTrig);
        int idx = 0, pass = 1, t = s + 2, g, n = 0;
        trig_t e;
        busyFrom = s + 1; busyTo = NEVER; expDone = -1;
        forever begin
            e.t = t; e.idx = idx; e.ch = pl[idx][19:16]; e.sa = pl[idx][15:0];
            expQ.push_back(e);
            n++;
            g = int'(pl[idx][30:20]);
            if (pl[idx][31] || idx == 63) begin
                if (loops != 0 && pass == loops) begin
                    expDone = t + BUSY + 2 + g;
                    busyTo  = expDone;
                    break;
                end
                pass++;
                idx = 0;
            end else begin
                idx++;
            end
            if (n == maxTrig) break;
            t = t + BUSY + 3 + g;
        end
    endtask

    task automatic clearSeen();
        trigSeen.delete();
        doneSeen = -1;
        doneCount = 0;
    endtask

    task automatic startRun(input int loops);
        iLoops = 16'(loops); iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    always @(negedge iClk) begin
        if (oTrig) trigSeen.push_back(cyc);
        if (oDone) begin doneSeen = cyc; doneCount++; end
        if (modelOn) begin
            expTrig = (expQ.size() > 0) && (expQ[0].t == cyc);
            chk("trig", 32'(oTrig), 32'(expTrig));
            if (expTrig) begin
                chk("ch", 32'(oAddr), 32'(expQ[0].ch));
                chk("start_addr", 32'(oStartAddr), 32'(expQ[0].sa));
                chk("entry_idx", 32'(oEntryIdx), 32'(expQ[0].idx));
                void'(expQ.pop_front());
            end
            chk("busy", 32'(oBusy), 32'(cyc >= busyFrom && cyc < busyTo));
            chk("done", 32'(oDone), 32'(cyc == expDone));
            chk("err", 32'(oErr), 32'(cyc >= errFrom && cyc < errTo));
        end
    end

    int s, t1;

    initial begin
        iReset = 1'b1; iWrEn = 1'b0; iWrAddr = '0; iWrData = '0;
        iStart = 1'b0; iAbort = 1'b0; iLoops = '0;
        tick(3);
        chk("rst_addr", 32'(oAddr), 0);
        chk("rst_trig", 32'(oTrig), 0);
        chk("rst_start", 32'(oStartAddr), 0);
        chk("rst_busy", 32'(oBusy), 0);
        chk("rst_done", 32'(oDone), 0);
        chk("rst_idx", 32'(oEntryIdx), 0);
        chk("rst_err", 32'(oErr), 0);
        iReset = 1'b0;
        wr(0, 32'h0000_0100);
        wr(1, 32'h8031_0200);
        tick();
        modelOn = 1;

        // Single pass.
        clearSeen(); s = cyc; plan(s, 1, 100); startRun(1);
        runTo(s + 40);
        chk("t1_trig_count", 32'(trigSeen.size()), 2);
        if (trigSeen.size() == 2) begin
            chk("t1_trig0_cycle", 32'(trigSeen[0] - s), 2);
            chk("t1_trig1_cycle", 32'(trigSeen[1] - s), 15);
        end
        chk("t1_done_cycle", 32'(doneSeen - s), 30);
        chk("t1_queue", 32'(expQ.size()), 0);

        // Three passes with a stray start while busy.
        clearSeen(); s = cyc; plan(s, 3, 100); startRun(3);
        runTo(s + 20);
        iStart = 1'b1; tick(); iStart = 1'b0;
        runTo(s + 95);
        chk("t2_trig_count", 32'(trigSeen.size()), 6);
        if (trigSeen.size() == 6) chk("t2_trig2_cycle", 32'(trigSeen[2] - s), 31);
        chk("t2_done_cycle", 32'(doneSeen - s), 88);
        chk("t2_done_count", 32'(doneCount), 1);
        chk("t2_queue", 32'(expQ.size()), 0);

        // Infinite loops, abort while entry 1 is still playing.
        clearSeen(); s = cyc; plan(s, 0, 2);
        t1 = s + 2 + BUSY + 3;
        expDone = t1 + BUSY + 2; busyTo = expDone;
        startRun(0);
        runTo(t1 + 4);
        iAbort = 1'b1; tick(); iAbort = 1'b0;
        runTo(s + 50);
        chk("t3_trig_count", 32'(trigSeen.size()), 2);
        chk("t3_done_cycle", 32'(doneSeen - s), 27);
        chk("t3_queue", 32'(expQ.size()), 0);

        // AWG never acknowledges.
        clearSeen(); awgMute = 1'b1; s = cyc; plan(s, 1, 1);
`ifdef AWG_SEQ_ACK_TIMEOUT_EN
        expDone = s + 11; busyTo = expDone; errFrom = s + 11; errTo = NEVER;
        startRun(1);
        runTo(s + 30);
        chk("t5_done_cycle", 32'(doneSeen - s), 11);
        chk("t5_err", 32'(oErr), 1);
        awgMute = 1'b0;
        clearSeen(); s = cyc; plan(s, 1, 100); errTo = s + 1; startRun(1);
        runTo(s + 40);
        chk("t5_err_cleared", 32'(oErr), 0);
`else
        startRun(1);
        runTo(s + 30);
        chk("t5_still_busy", 32'(oBusy), 1);
        busyTo = cyc + 1;
        iReset = 1'b1; tick(); iReset = 1'b0;
        chk("t5_busy_after_rst", 32'(oBusy), 0);
        awgMute = 1'b0;
        tick(5);
`endif
        chk("t5_trig_total", 32'(trigSeen.size()) > 0, 1);

        // Reset in the gap after entry 1.
        clearSeen(); s = cyc; plan(s, 1, 100); startRun(1);
        runTo(s + 28);
        busyTo = s + 29; expDone = -1;
        iReset = 1'b1; tick(); iReset = 1'b0;
        chk("t4_rst_addr", 32'(oAddr), 0);
        chk("t4_rst_start", 32'(oStartAddr), 0);
        chk("t4_rst_idx", 32'(oEntryIdx), 0);
        chk("t4_rst_busy", 32'(oBusy), 0);
        chk("t4_rst_done", 32'(oDone), 0);
        tick(20);
        chk("t4_trig_count", 32'(trigSeen.size()), 2);
        chk("t4_no_done", 32'(doneCount), 0);

        modelOn = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
